// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
//
// Consumer end of a single-clock 64x8 FIFO. Waits until the FIFO holds a full
// burst, then drains exactly that many words by strobing fifo_rd_en. Each word
// is captured into a small skid buffer and presented on a valid/ready stream.
// The final word of every burst is tagged with m_last.
//
// Optional build macro: FIFO_RD_TIMEOUT_EN
//   When defined, a partial fill that sits idle for TIMEOUT_CYC cycles is
//   flushed as a short burst. When undefined, len is always BURST_LEN and
//   sub-threshold words wait in the FIFO.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous reset, active-high
//   fifo_rd_en     out  read strobe to the FIFO
//   fifo_buf_out   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_buf_empty in   FIFO empty flag
//   fifo_counter   in   FIFO occupancy
//   m_data         out  downstream data
//   m_valid        out  m_data valid
//   m_ready        in   downstream accept
//   m_last         out  final word of a burst
//   burst_active   out  high from burst start until its last word is accepted
//   burst_count    out  completed bursts, wraps at 2^16
// ---------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 8,
  parameter int BURST_LEN   = 16,
  parameter int SKID_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_buf_out,
  input  logic              fifo_buf_empty,
  input  logic [CNT_W-1:0]  fifo_counter,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              burst_active,
  output logic [15:0]       burst_count
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [OCC_W:0]   DEPTH_C     = (OCC_W + 1)'(SKID_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0]     r_mem_data [SKID_DEPTH];
  logic [SKID_DEPTH-1:0] r_mem_last;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [CNT_W-1:0]      r_len;
  logic [CNT_W-1:0]      r_issued;
  logic [15:0]           r_burst_count;

  logic                  w_start_req;
  logic [CNT_W-1:0]      w_start_len;
  logic                  w_start;
  logic                  w_credit;
  logic                  w_rd_en;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_head_last;
  logic                  w_last_accept;

  // -------------------------------------------------------------------------
  // Burst start decision (threshold, optionally idle-timeout flush)
  // -------------------------------------------------------------------------
`ifdef FIFO_RD_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic              w_idle_win;
  logic              w_full_burst;

  assign w_full_burst = (fifo_counter >= BURST_LEN_C);
  assign w_idle_win   = (r_state == S_IDLE) && (fifo_counter != '0) && !w_full_burst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (w_idle_win) begin
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end else begin
      r_idle_cnt <= '0;
    end
  end

  // The increment that would reach TIMEOUT_CYC launches the flush instead.
  assign w_start_req = w_full_burst ||
                       (w_idle_win && (r_idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)));
  assign w_start_len = w_full_burst ? BURST_LEN_C : fifo_counter;
`else
  // TIMEOUT_CYC only matters when the flush feature is built.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);

  assign w_start_req = (fifo_counter >= BURST_LEN_C);
  assign w_start_len = BURST_LEN_C;
`endif

  // -------------------------------------------------------------------------
  // Read issue: credit counts both buffered words and the one in flight
  // -------------------------------------------------------------------------
  assign w_credit = ({1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight}) < DEPTH_C;
  assign w_rd_en  = (r_state == S_BURST) && !fifo_buf_empty &&
                    (r_issued < r_len) && w_credit;

  assign w_valid       = (r_occ != '0);
  assign w_push        = r_inflight;
  assign w_pop         = w_valid && m_ready;
  assign w_head_last   = r_mem_last[r_rd_ptr];
  assign w_last_accept = w_pop && w_head_last;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_req) begin
          w_state_nxt = S_BURST;
          w_start     = 1'b1;
        end
      end
      S_BURST: begin
        if (r_issued == r_len) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_accept) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_len           <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_burst_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_len    <= w_start_len;
        r_issued <= '0;
      end else if (w_rd_en) begin
        r_issued <= r_issued + CNT_W'(1);
      end
      // A word read mid-reset is dropped simply by clearing the in-flight flag.
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en && (r_issued == r_len - CNT_W'(1));
      if (w_last_accept) begin
        r_burst_count <= r_burst_count + 16'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Capture: FIFO data lands in the skid buffer one cycle after the strobe
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= fifo_buf_out;
      r_mem_last[r_wr_ptr] <= r_inflight_last;
    end
  end

  // -------------------------------------------------------------------------
  // Output stream: head of the skid buffer, forced to zero while empty
  // -------------------------------------------------------------------------
  assign fifo_rd_en   = w_rd_en;
  assign m_valid      = w_valid;
  assign m_data       = w_valid ? r_mem_data[r_rd_ptr] : '0;
  assign m_last       = w_valid && w_head_last;
  assign burst_active = (r_state != S_IDLE);
  assign burst_count  = r_burst_count;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Drives fifo_burst_reader from a behavioural 64-entry FIFO with registered
// read data. The reference model is a queue of every byte written since the
// last reset: the stream must deliver them in order, every BURST_LEN-th
// delivered word carries m_last, and burst_count counts those words.
// ---------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int DATA_W     = 8;
  localparam int CNT_W      = 8;
  localparam int BURST_LEN  = 16;
  localparam int SKID_DEPTH = 4;

  logic              clk;
  logic              rst;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_buf_out;
  logic              fifo_buf_empty;
  logic [CNT_W-1:0]  fifo_counter;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              burst_active;
  logic [15:0]       burst_count;

  logic              wr_en;
  logic [7:0]        wr_data;

  fifo_burst_reader #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN),
    .SKID_DEPTH(SKID_DEPTH), .TIMEOUT_CYC(255)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_rd_en(fifo_rd_en), .fifo_buf_out(fifo_buf_out),
    .fifo_buf_empty(fifo_buf_empty), .fifo_counter(fifo_counter),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .burst_active(burst_active), .burst_count(burst_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural FIFO shared with the DUT reset.
  logic [7:0] fq[$];
  logic [7:0] fcnt;
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fcnt <= 8'd0;
    end else begin
      if (fifo_rd_en && fq.size() != 0) fifo_buf_out <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      fcnt <= 8'(fq.size());
    end
  end
  assign fifo_counter   = fcnt;
  assign fifo_buf_empty = (fcnt == 8'd0);

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  // Reference model state and observation logs
  logic [7:0] exp_q[$];
  int         acc_n;
  int         bc_model;
  int         cyc;
  int         valid_seen;
  int         rd_log[$];
  int         acc_cyc[$];
  int         acc_data[$];
  int         acc_last[$];

  task automatic chk(input bit ok, input string name, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_bytes(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(base + i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_bc(input int n, input int limit, input string name);
    int k;
    k = 0;
    while (bc_model < n && k < limit) begin
      tick();
      k++;
    end
    if (bc_model < n) chk(1'b0, name, bc_model, n);
    tick();
  endtask

  initial begin
    bit         stalled;
    logic [7:0] hold_data;
    logic       hold_last;
    int         r0, a0, v0, k;
    logic [7:0] e;
    bit         e_last;

    rst = 1'b1; m_ready = 1'b0; wr_en = 1'b0; wr_data = 8'd0;
    acc_n = 0; bc_model = 0; cyc = 0; valid_seen = 0;
    stalled = 1'b0; hold_data = '0; hold_last = 1'b0;

    fork
      begin : compare
        forever begin
          @(negedge clk);
          cyc++;
          if (rst) begin
            exp_q.delete();
            acc_n    = 0;
            bc_model = 0;
            stalled  = 1'b0;
          end else begin
            chk(!(fifo_rd_en && fifo_buf_empty), "rd_when_empty", int'(fifo_rd_en), 0);
            chk(int'(burst_count) == bc_model, "burst_count_track", int'(burst_count), bc_model);
            if (stalled) begin
              chk(m_valid == 1'b1, "stall_valid", int'(m_valid), 1);
              chk(m_data == hold_data, "stall_data", int'(m_data), int'(hold_data));
              chk(m_last == hold_last, "stall_last", int'(m_last), int'(hold_last));
            end
            if (fifo_rd_en) rd_log.push_back(cyc);
            if (m_valid) valid_seen++;
            if (m_valid && m_ready) begin
              if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_word", int'(m_data), -1);
              end else begin
                e      = exp_q.pop_front();
                e_last = ((acc_n + 1) % BURST_LEN) == 0;
                chk(m_data == e, "stream_data", int'(m_data), int'(e));
                chk(m_last == e_last, "stream_last", int'(m_last), int'(e_last));
                acc_n++;
                if (e_last) bc_model = (bc_model + 1) % 65536;
              end
              acc_cyc.push_back(cyc);
              acc_data.push_back(int'(m_data));
              acc_last.push_back(int'(m_last));
            end
            stalled   = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
            if (wr_en) exp_q.push_back(wr_data);
          end
        end
      end
      begin : stimulus
        repeat (3) tick();
        rst = 1'b0;
        // Reset state
        chk(m_valid == 1'b0, "rst_m_valid", int'(m_valid), 0);
        chk(m_data == 8'd0, "rst_m_data", int'(m_data), 0);
        chk(m_last == 1'b0, "rst_m_last", int'(m_last), 0);
        chk(fifo_rd_en == 1'b0, "rst_rd_en", int'(fifo_rd_en), 0);
        chk(burst_active == 1'b0, "rst_burst_active", int'(burst_active), 0);
        chk(burst_count == 16'd0, "rst_burst_count", int'(burst_count), 0);

        // Below threshold: nothing is read
        r0 = rd_log.size(); v0 = valid_seen;
        m_ready = 1'b1;
        write_bytes(8'h01, 10);
        repeat (40) tick();
        chk(rd_log.size() == r0, "short_no_reads", rd_log.size() - r0, 0);
        chk(valid_seen == v0, "short_no_valid", valid_seen - v0, 0);
        chk(burst_active == 1'b0, "short_burst_active", int'(burst_active), 0);
        chk(fifo_counter == 8'd10, "short_fifo_count", int'(fifo_counter), 10);

        // One full burst at full throughput
        do_reset();
        r0 = rd_log.size(); a0 = acc_cyc.size();
        write_bytes(8'h01, 16);
        wait_bc(1, 200, "burst1_timeout");
        chk(rd_log.size() - r0 == 16, "b1_reads", rd_log.size() - r0, 16);
        if (rd_log.size() - r0 >= 16)
          chk(rd_log[r0+15] - rd_log[r0] == 15, "b1_rd_consecutive", rd_log[r0+15] - rd_log[r0], 15);
        chk(acc_cyc.size() - a0 == 16, "b1_accepts", acc_cyc.size() - a0, 16);
        if (acc_cyc.size() - a0 >= 16) begin
          chk(acc_cyc[a0+15] - acc_cyc[a0] == 15, "b1_acc_consecutive", acc_cyc[a0+15] - acc_cyc[a0], 15);
          chk(acc_data[a0] == 8'h01, "b1_first_data", acc_data[a0], 1);
          chk(acc_data[a0+15] == 8'h10, "b1_last_data", acc_data[a0+15], 16);
          chk(acc_last[a0+15] == 1, "b1_last_flag", acc_last[a0+15], 1);
          chk(acc_last[a0+14] == 0, "b1_not_last_flag", acc_last[a0+14], 0);
        end
        chk(burst_count == 16'd1, "b1_burst_count", int'(burst_count), 1);
        chk(fifo_buf_empty == 1'b1, "b1_fifo_empty", int'(fifo_buf_empty), 1);
        chk(burst_active == 1'b0, "b1_idle_after", int'(burst_active), 0);

        // Backpressure: only SKID_DEPTH reads while stalled, then four bursts
        do_reset();
        m_ready = 1'b0;
        r0 = rd_log.size(); a0 = acc_cyc.size();
        write_bytes(8'h20, 64);
        repeat (20) tick();
        chk(rd_log.size() - r0 == SKID_DEPTH, "bp_reads_stalled", rd_log.size() - r0, SKID_DEPTH);
        chk(m_valid == 1'b1, "bp_valid_stalled", int'(m_valid), 1);
        chk(m_data == 8'h20, "bp_head_data", int'(m_data), 32);
        chk(burst_active == 1'b1, "bp_active", int'(burst_active), 1);
        m_ready = 1'b1;
        wait_bc(4, 600, "bp_timeout");
        chk(burst_count == 16'd4, "bp_burst_count", int'(burst_count), 4);
        chk(acc_cyc.size() - a0 == 64, "bp_accepts", acc_cyc.size() - a0, 64);
        chk(exp_q.size() == 0, "bp_model_drained", exp_q.size(), 0);
        chk(fifo_buf_empty == 1'b1, "bp_fifo_empty", int'(fifo_buf_empty), 1);

        // Toggling ready during a burst
        do_reset();
        m_ready = 1'b0;
        a0 = acc_cyc.size();
        write_bytes(8'hA0, 16);
        k = 0;
        while (bc_model < 1 && k < 300) begin
          m_ready = ~m_ready;
          tick();
          k++;
        end
        if (bc_model < 1) chk(1'b0, "toggle_timeout", bc_model, 1);
        m_ready = 1'b1;
        tick();
        chk(burst_count == 16'd1, "tg_burst_count", int'(burst_count), 1);
        chk(acc_cyc.size() - a0 == 16, "tg_accepts", acc_cyc.size() - a0, 16);
        if (acc_cyc.size() - a0 >= 16) begin
          chk(acc_data[a0] == 8'hA0, "tg_first_data", acc_data[a0], 160);
          chk(acc_data[a0+15] == 8'hAF, "tg_last_data", acc_data[a0+15], 175);
        end

        // Reset mid-burst after 7 accepted words, then a fresh burst
        do_reset();
        m_ready = 1'b1;
        a0 = acc_cyc.size();
        write_bytes(8'h50, 16);
        k = 0;
        while (acc_cyc.size() - a0 < 7 && k < 100) begin
          tick();
          k++;
        end
        chk(acc_cyc.size() - a0 == 7, "mid_accepts_before_rst", acc_cyc.size() - a0, 7);
        m_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk(m_valid == 1'b0, "mid_rst_valid", int'(m_valid), 0);
        chk(m_data == 8'd0, "mid_rst_data", int'(m_data), 0);
        chk(m_last == 1'b0, "mid_rst_last", int'(m_last), 0);
        chk(fifo_rd_en == 1'b0, "mid_rst_rd_en", int'(fifo_rd_en), 0);
        chk(burst_active == 1'b0, "mid_rst_active", int'(burst_active), 0);
        chk(burst_count == 16'd0, "mid_rst_count", int'(burst_count), 0);
        m_ready = 1'b1;
        a0 = acc_cyc.size();
        write_bytes(8'h60, 16);
        wait_bc(1, 200, "refill_timeout");
        chk(burst_count == 16'd1, "refill_burst_count", int'(burst_count), 1);
        chk(acc_cyc.size() - a0 == 16, "refill_accepts", acc_cyc.size() - a0, 16);
        if (acc_cyc.size() - a0 >= 16) begin
          chk(acc_data[a0] == 8'h60, "refill_first_data", acc_data[a0], 96);
          chk(acc_data[a0+15] == 8'h6F, "refill_last_data", acc_data[a0+15], 111);
          chk(acc_last[a0+15] == 1, "refill_last_flag", acc_last[a0+15], 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join
  end

endmodule
